// File: rtl/rx_comma_aligner.sv
// K28.5 comma aligner: finds the comma bit offset in the raw deserializer
// stream, locks onto it and emits aligned 10-bit symbols downstream.
module rx_comma_aligner #(
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned UNLOCK_CNT = 4,
   parameter logic [9:0]  COMMA_P    = 10'b0011111010,
   parameter logic [9:0]  COMMA_N    = 10'b1100000101
) (
   input  logic       rclk,
   input  logic       rrst_n,
   input  logic [9:0] data_in,
   input  logic       data_in_vld,
   output logic [9:0] data_out,
   output logic       data_out_vld,
   output logic       comma_det,
   output logic       locked,
   output logic [3:0] align_off
);

   localparam logic [3:0] LCNT = 4'(LOCK_CNT);
   localparam logic [3:0] UCNT = 4'(UNLOCK_CNT);

   typedef enum logic [1:0] {
      SEARCH,
      CHECK,
      LOCKED
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] lcnt;
   logic [3:0] lcnt_nx;
   logic [3:0] ecnt;
   logic [3:0] ecnt_nx;
   logic [3:0] off_nx;
   logic [9:0] prev_word;
   logic       primed;

   logic [19:0] win;
   logic [9:0]  cand [10];
   logic [9:0]  hit;
   logic        any_hit;
   logic        hit_here;
   logic        miss;
   logic [3:0]  hit_k;
   logic [9:0]  sel;
   logic        sel_comma;
   logic [3:0]  lcnt_inc;
   logic [3:0]  ecnt_inc;

   // primed masks the very first word after reset, whose window is half empty
   always_comb begin
      win = {data_in, prev_word};
      for (int k = 0; k < 10; k++) begin
         cand[k] = win[k +: 10];
         hit[k]  = primed &&
                   ((cand[k] == COMMA_P) ||
                    (cand[k] == COMMA_N));
      end
   end

   always_comb begin
      hit_k = 4'd0;
      for (int k = 9; k >= 0; k--) begin
         if (hit[k]) hit_k = 4'(k);
      end
   end

   assign any_hit  = |hit;
   assign hit_here = hit[align_off];
   assign miss     = any_hit & ~hit_here;
   assign lcnt_inc = lcnt + 4'd1;
   assign ecnt_inc = ecnt + 4'd1;

   always_comb begin
      state_nx = state;
      lcnt_nx  = lcnt;
      ecnt_nx  = ecnt;
      off_nx   = align_off;
      if (data_in_vld) begin
         unique case (state)
            SEARCH: begin
               if (any_hit) begin
                  off_nx  = hit_k;
                  lcnt_nx = 4'd1;
                  if (LCNT == 4'd1) begin
                     state_nx = LOCKED;
                     ecnt_nx  = 4'd0;
                  end else begin
                     state_nx = CHECK;
                  end
               end
            end
            CHECK: begin
               unique case (1'b1)
                  hit_here: begin
                     lcnt_nx = lcnt_inc;
                     if (lcnt_inc == LCNT) begin
                        state_nx = LOCKED;
                        ecnt_nx  = 4'd0;
                     end
                  end
                  miss: begin
                     off_nx  = hit_k;
                     lcnt_nx = 4'd1;
                  end
                  default: ;
               endcase
            end
            LOCKED: begin
               // offset is frozen here; only the error count moves
               unique case (1'b1)
                  hit_here: ecnt_nx = 4'd0;
                  miss: begin
                     ecnt_nx = ecnt_inc;
                     if (ecnt_inc == UCNT) begin
                        state_nx = SEARCH;
                     end
                  end
                  default: ;
               endcase
            end
            default: state_nx = SEARCH;
         endcase
      end
   end

   always_comb begin
      sel       = cand[off_nx];
      sel_comma = hit[off_nx];
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state        <= SEARCH;
         lcnt         <= 4'd0;
         ecnt         <= 4'd0;
         align_off    <= 4'd0;
         prev_word    <= 10'd0;
         primed       <= 1'b0;
         data_out     <= 10'd0;
         data_out_vld <= 1'b0;
         comma_det    <= 1'b0;
      end else if (data_in_vld) begin
         state        <= state_nx;
         lcnt         <= lcnt_nx;
         ecnt         <= ecnt_nx;
         align_off    <= off_nx;
         prev_word    <= data_in;
         primed       <= 1'b1;
         data_out     <= sel;
         data_out_vld <= (state_nx == LOCKED);
         comma_det    <= sel_comma;
      end else begin
         data_out_vld <= 1'b0;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Bench for rx_comma_aligner: bit-stream driver feeding a scoreboard,
// monitor pops on every data_out_vld.
module tb_rx_comma_aligner;

   localparam logic [9:0] CP = 10'b0011111010;
   localparam logic [9:0] CN = 10'b1100000101;
   localparam logic [9:0] DS = 10'b1010101010;

   logic       rclk = 1'b0;
   logic       rrst_n = 1'b0;
   logic [9:0] data_in = 10'd0;
   logic       data_in_vld = 1'b0;
   logic [9:0] data_out;
   logic       data_out_vld;
   logic       comma_det;
   logic       locked;
   logic [3:0] align_off;

   bit          bq [$];
   logic [10:0] sb [$];
   logic [9:0]  prev_w = 10'd0;
   logic [9:0]  ph;
   int          n_cmp = 0;
   int          n_bad = 0;

   rx_comma_aligner dut (
      .rclk         (rclk),
      .rrst_n       (rrst_n),
      .data_in      (data_in),
      .data_in_vld  (data_in_vld),
      .data_out     (data_out),
      .data_out_vld (data_out_vld),
      .comma_det    (comma_det),
      .locked       (locked),
      .align_off    (align_off)
   );

   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic add_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) bq.push_back(s[i]);
   endtask

   task automatic add_pad(input int n);
      for (int i = 0; i < n; i++) bq.push_back(bit'(i % 2 == 0));
   endtask

   task automatic add_pairs(input int n);
      for (int i = 0; i < n; i++) begin
         add_sym(CP);
         add_sym(DS);
      end
   endtask

   task automatic emit(input bit ev, input int k);
      logic [9:0]  w;
      logic [19:0] win;
      logic [9:0]  e;
      for (int i = 0; i < 10; i++) begin
         w[i] = (bq.size() > 0) ? bq.pop_front() : 1'b0;
      end
      @(negedge rclk);
      data_in     = w;
      data_in_vld = 1'b1;
      win = {w, prev_w};
      e   = win[k +: 10];
      if (ev) sb.push_back({e, (e == CP) || (e == CN)});
      prev_w = w;
   endtask

   task automatic emitn(input int n, input bit ev, input int k);
      for (int i = 0; i < n; i++) emit(ev, k);
   endtask

   task automatic idle();
      @(negedge rclk);
      data_in_vld = 1'b0;
      data_in     = CN;
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) idle();
   endtask

   task automatic peek();
      @(posedge rclk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge rclk);
      rrst_n      = 1'b0;
      data_in_vld = 1'b0;
      #2;
      chk("rst_data", data_out, 0);
      chk("rst_vld", data_out_vld, 0);
      chk("rst_locked", locked, 0);
      chk("rst_off", align_off, 0);
      @(negedge rclk);
      rrst_n = 1'b1;
      bq.delete();
      prev_w = 10'd0;
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      ph = CP >> 1;
      fork
         forever begin
            logic [10:0] e;
            @(negedge rclk);
            if (data_out_vld === 1'b1) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_out: got %0h want none",
                           data_out);
               end else begin
                  e = sb.pop_front();
                  if ({data_out, comma_det} !== e) begin
                     n_bad++;
                     $display("FAIL out: got %0h/%0b want %0h/%0b",
                              data_out, comma_det, e[10:1], e[0]);
                  end
               end
            end
         end
      join_none

      // shift 3, comma + data pairs
      do_reset();
      add_pad(3);
      add_pairs(5);
      emit(0, 3);
      emit(0, 3);
      peek();
      chk("t1_off", align_off, 3);
      chk("t1_unlocked", locked, 0);
      emitn(3, 0, 3);
      emit(1, 3);
      peek();
      chk("t1_locked", locked, 1);
      emitn(4, 1, 3);
      idles(3);

      // alternating polarity, gapped input
      do_reset();
      for (int i = 0; i < 3; i++) begin
         add_sym(CP);
         add_sym(CN);
      end
      for (int i = 0; i < 6; i++) begin
         emit(i >= 3, 0);
         idle();
         peek();
         chk("t2_idle_vld", data_out_vld, 0);
         if (i == 2) chk("t2_pre_lock", locked, 0);
         if (i == 3) begin
            chk("t2_locked", locked, 1);
            chk("t2_hold", data_out, CP);
         end
      end
      idles(3);

      // offset change 5 -> 7 while checking
      do_reset();
      add_pad(5);
      add_pairs(2);
      add_pad(2);
      add_pairs(4);
      emitn(4, 0, 5);
      peek();
      chk("t3_off5", align_off, 5);
      emitn(2, 0, 7);
      peek();
      chk("t3_off7", align_off, 7);
      chk("t3_nolock", locked, 0);
      emitn(3, 0, 7);
      peek();
      chk("t3_nolock2", locked, 0);
      emit(1, 7);
      peek();
      chk("t3_locked", locked, 1);
      emitn(2, 1, 7);
      idles(3);

      // four misaligned commas drop lock
      do_reset();
      add_pad(2);
      add_pairs(3);
      add_pad(4);
      add_pairs(4);
      emitn(5, 0, 2);
      emit(1, 2);
      peek();
      chk("t4_locked", locked, 1);
      emitn(7, 1, 2);
      peek();
      chk("t4_held", locked, 1);
      emit(0, 2);
      peek();
      chk("t4_unlock", locked, 0);
      chk("t4_vld", data_out_vld, 0);
      chk("t4_off", align_off, 2);
      idles(3);

      // aligned comma between misaligned runs clears error count
      do_reset();
      add_pad(2);
      add_pairs(3);
      add_pad(4);
      add_pairs(3);
      add_pad(6);
      add_pairs(1);
      add_pad(4);
      add_pairs(3);
      emitn(5, 0, 2);
      emitn(16, 1, 2);
      peek();
      chk("t4b_locked", locked, 1);
      chk("t4b_off", align_off, 2);
      idles(3);

      // commas at offsets 0 and 9 in one window
      do_reset();
      add_sym(CP);
      add_sym(ph);
      add_sym(CP);
      add_sym(CP);
      add_sym(CP);
      add_sym(DS);
      emit(0, 0);
      emit(0, 0);
      peek();
      chk("t5_lowest", align_off, 0);
      emitn(2, 0, 0);
      emitn(2, 1, 0);
      peek();
      chk("t5_locked", locked, 1);
      idles(3);

      // async reset while locked, then reacquire
      do_reset();
      add_pairs(3);
      emitn(5, 0, 0);
      emit(1, 0);
      idles(2);
      peek();
      chk("t6_locked", locked, 1);
      chk("t6_comma", comma_det, 1);
      #3;
      rrst_n = 1'b0;
      #1;
      chk("t6_rst_data", data_out, 0);
      chk("t6_rst_vld", data_out_vld, 0);
      chk("t6_rst_comma", comma_det, 0);
      chk("t6_rst_locked", locked, 0);
      @(negedge rclk);
      rrst_n = 1'b1;
      bq.delete();
      prev_w = 10'd0;
      add_sym(ph);
      add_pad(4);
      add_pairs(3);
      emit(0, 0);
      peek();
      chk("t6_first_word", align_off, 0);
      emitn(5, 0, 4);
      emit(1, 4);
      peek();
      chk("t6_relock", locked, 1);
      chk("t6_off", align_off, 4);
      idles(3);

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
